hilo_unit: RTL and testbench
============================

# hilo_unit

HI/LO architectural register unit sitting directly downstream of the multi-cycle multiplier in the execute stage. It captures the 64-bit product when the multiplier signals completion, writes MTHI/MTLO operands, and performs MADD/MADDU/MSUB/MSUBU through a two-state accumulate sequence with a busy output that stalls the pipeline. It provides the committed HI/LO values to MFHI/MFLO consumers and discards in-flight work on flush.

## Interface
Parameters:
- `WIDTH`, 32, architectural register width; HI/LO are each `WIDTH`, product is `2*WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush; same priority as `rst` for in-flight work.
- `en`  in  1  execute-stage instruction valid and not stalled elsewhere.
- `hilo_op`  in  3  operation code (encodings in package).
- `mul_valid`  in  1  multiplier result valid this cycle (multiplier stall just dropped).
- `mul_result`  in  64  sign-correct product from the multiplier.
- `rs_data`  in  32  source operand for MTHI/MTLO.
- `hi_o`  out  32  committed HI.
- `lo_o`  out  32  committed LO.
- `busy`  out  1  accumulate in progress; upstream must hold.

## Operation
- Opcodes: `HILO_NONE`=0, `HILO_MTHI`=1, `HILO_MTLO`=2, `HILO_MUL`=3, `HILO_MADD`=4, `HILO_MSUB`=5; 6,7 treated as NONE.
- Accept condition: `en && !busy && !flush`.
- MTHI/MTLO: on accept, HI (resp. LO) <= `rs_data` at the edge; other half unchanged.
- MUL: on accept with `mul_valid`=1, {HI,LO} <= `mul_result`. With `mul_valid`=0 nothing happens (multiplier still running).
- MADD/MSUB: on accept with `mul_valid`=1, register product into `prod_q`, latch sign `sub_q`, go to ACC. In ACC: {HI,LO} <= {HI,LO} + `prod_q` (MADD) or − `prod_q` (MSUB), return IDLE.
- Arithmetic: 64-bit modulo 2^64, no overflow flag; signed/unsigned variants share the datapath because the product is already correctly extended.
- FSM: IDLE -> ACC (MADD/MSUB accepted); ACC -> IDLE unconditionally after one cycle; any state -> IDLE on `rst` or `flush`.
- `busy` = (state == ACC), registered.
- Flush in ACC: accumulate write suppressed, HI/LO keep pre-instruction values. Flush in IDLE: no write for that cycle's op.
- Reset: HI=0, LO=0, `prod_q`=0, state IDLE, `busy`=0.

## Timing
- MTHI/MTLO/MUL: write visible on `hi_o`/`lo_o` the cycle after accept (1-cycle latency).
- MADD/MSUB: accept at cycle N, `busy`=1 during N+1, result visible at N+2 (2-cycle latency).
- `hi_o`/`lo_o` are register outputs; no bypass of same-cycle writes. MFHI/MFLO after a write is covered by pipeline ordering plus `busy`.
- While `busy`=1, `en`, `hilo_op`, `mul_result` are ignored.
- `rst` and `flush` asserted together: reset wins (HI/LO cleared).
- Back-to-back MADD: second accepted only in the cycle `busy` falls, reads the already-updated HI/LO.

## Structure
- Shared package `hilo_pkg`: `hilo_op` encodings, state enum (IDLE, ACC), `HILO_W`=32.
- Single module, no sub-modules; 64-bit add/sub inline.

## Test plan
- Reset then MTHI 0x1234_5678, MTLO 0x9ABC_DEF0 -> `hi_o`=0x12345678, `lo_o`=0x9ABCDEF0 one cycle after each.
- MUL with `mul_valid`=0 for 3 cycles then 1, `mul_result`=0xFFFF_FFFF_FFFF_FFFE -> HI/LO unchanged until the valid cycle, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- HI/LO=0x0000_0000_FFFF_FFFF, MADD product 1 -> `busy` high 1 cycle, result HI=1, LO=0 (carry across halves).
- HI/LO=0, MSUB product 1 -> HI=LO=0xFFFFFFFF (wrap-around).
- MADD accepted, `flush`=1 during ACC -> no write, `busy`=0 next cycle, HI/LO unchanged.
- `rst` and `flush` together while in ACC with nonzero HI/LO -> HI=LO=0, `busy`=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register unit: operation encodings,
// accumulate sequencer states and the architectural register width.
package hilo_pkg;

  localparam int HILO_W = 32;

  typedef enum logic [2:0] {
    HILO_NONE = 3'd0,
    HILO_MTHI = 3'd1,
    HILO_MTLO = 3'd2,
    HILO_MUL  = 3'd3,
    HILO_MADD = 3'd4,
    HILO_MSUB = 3'd5
  } hilo_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } hilo_state_e;

endpackage

// File: rtl/hilo_unit.sv
// HI/LO architectural registers behind the multiplier: product capture,
// MTHI/MTLO writes and a two-cycle MADD/MSUB accumulate with pipeline stall.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               en,
  input  logic [2:0]         hilo_op,
  input  logic               mul_valid,
  input  logic [2*WIDTH-1:0] mul_result,
  input  logic [WIDTH-1:0]   rs_data,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               busy
);

  // Modulo-2^(2*WIDTH) accumulate; signed and unsigned forms share it since
  // the multiplier already delivers a correctly extended product.
  function automatic logic signed [2*WIDTH-1:0] accumulate(
    input logic signed [2*WIDTH-1:0] acc,
    input logic signed [2*WIDTH-1:0] prod,
    input logic                      sub
  );
    return sub ? (acc - prod) : (acc + prod);
  endfunction

  hilo_state_e               state_q;
  hilo_state_e               state_d;
  logic signed [2*WIDTH-1:0] hilo_q;
  logic signed [2*WIDTH-1:0] prod_q;
  logic                      sub_q;
  logic                      accept;
  logic                      acc_start;

  assign busy      = (state_q == ACC);
  assign accept    = en && !busy && !flush;
  assign acc_start = accept && mul_valid &&
                     ((hilo_op == HILO_MADD) || (hilo_op == HILO_MSUB));

  always_ff @(posedge clk) begin
    if (rst || flush) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_start) state_d = ACC;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: op accept (IDLE) or accumulate write-back (ACC)
  always_ff @(posedge clk) begin
    if (rst) begin
      hilo_q <= '0;
      prod_q <= '0;
      sub_q  <= 1'b0;
    end else if (flush) begin
      hilo_q <= hilo_q;
    end else if (state_q == ACC) begin
      hilo_q <= accumulate(hilo_q, prod_q, sub_q);
    end else if (accept) begin
      case (hilo_op)
        HILO_MTHI: hilo_q[2*WIDTH-1:WIDTH] <= rs_data;
        HILO_MTLO: hilo_q[WIDTH-1:0]       <= rs_data;
        HILO_MUL:  if (mul_valid) hilo_q <= mul_result;
        HILO_MADD, HILO_MSUB: begin
          if (mul_valid) begin
            prod_q <= mul_result;
            sub_q  <= (hilo_op == HILO_MSUB);
          end
        end
        default: hilo_q <= hilo_q;
      endcase
    end
  end

  assign hi_o = hilo_q[2*WIDTH-1:WIDTH];
  assign lo_o = hilo_q[WIDTH-1:0];

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: directed corner cases then random traffic,
// each cycle's expected HI/LO/busy predicted by a behavioural model.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  hilo_op = 3'd0;
  logic        mul_valid = 1'b0;
  logic [63:0] mul_result = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;

  hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .en(en), .hilo_op(hilo_op),
    .mul_valid(mul_valid), .mul_result(mul_result), .rs_data(rs_data),
    .hi_o(hi_o), .lo_o(lo_o), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: architectural 64-bit value plus at most one pending delta
  logic [63:0] m_val = '0;
  logic [63:0] m_delta = '0;
  bit          m_pending = 0;

  task automatic model_step();
    if (rst) begin
      m_val = '0;
      m_pending = 0;
    end else if (flush) begin
      m_pending = 0;
    end else if (m_pending) begin
      m_val = m_val + m_delta;
      m_pending = 0;
    end else if (en) begin
      case (hilo_op)
        3'd1: m_val[63:32] = rs_data;
        3'd2: m_val[31:0]  = rs_data;
        3'd3: if (mul_valid) m_val = mul_result;
        3'd4: if (mul_valid) begin m_delta = mul_result;      m_pending = 1; end
        3'd5: if (mul_valid) begin m_delta = 64'd0 - mul_result; m_pending = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic e, input logic [2:0] op,
                       input logic mv, input logic [63:0] res, input logic [31:0] rs);
    exp_t x;
    @(negedge clk);
    rst = r; flush = f; en = e; hilo_op = op;
    mul_valid = mv; mul_result = res; rs_data = rs;
    model_step();
    x.hi = m_val[63:32];
    x.lo = m_val[31:0];
    x.busy = m_pending;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 3'd0, 0, {$urandom, $urandom}, $urandom);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: compare outputs just after each active edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("hi_o", hi_o, e.hi);
      check("lo_o", lo_o, e.lo);
      check("busy", {31'd0, busy}, {31'd0, e.busy});
    end
  end

  initial begin
    drive(1, 0, 0, 3'd0, 0, '0, '0);
    drive(1, 0, 0, 3'd0, 0, '0, '0);
    // MTHI / MTLO
    drive(0, 0, 1, 3'd1, 0, '0, 32'h1234_5678);
    drive(0, 0, 1, 3'd2, 0, '0, 32'h9ABC_DEF0);
    // MUL waiting on the multiplier
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 3'd3, 0, 64'h1111_2222_3333_4444, '0);
    drive(0, 0, 1, 3'd3, 1, 64'hFFFF_FFFF_FFFF_FFFE, '0);
    idle(1);
    // MADD carry across halves
    drive(0, 0, 1, 3'd1, 0, '0, 32'h0);
    drive(0, 0, 1, 3'd2, 0, '0, 32'hFFFF_FFFF);
    drive(0, 0, 1, 3'd4, 1, 64'd1, '0);
    drive(0, 0, 1, 3'd4, 1, 64'hDEAD_BEEF_0000_0000, '0);  // ignored while busy
    idle(2);
    // MSUB wrap-around
    drive(0, 0, 1, 3'd1, 0, '0, 32'h0);
    drive(0, 0, 1, 3'd2, 0, '0, 32'h0);
    drive(0, 0, 1, 3'd5, 1, 64'd1, '0);
    idle(2);
    // Flush during ACC
    drive(0, 0, 1, 3'd4, 1, 64'd5, '0);
    drive(0, 1, 0, 3'd0, 0, '0, '0);
    idle(2);
    // Flush in IDLE suppresses the op
    drive(0, 1, 1, 3'd1, 0, '0, 32'hCAFE_F00D);
    idle(1);
    // Back-to-back MADD held across busy
    drive(0, 0, 1, 3'd4, 1, 64'h0000_0001_0000_0003, '0);
    drive(0, 0, 1, 3'd4, 1, 64'h0000_0002_0000_0007, '0);
    drive(0, 0, 1, 3'd4, 1, 64'h0000_0002_0000_0007, '0);
    idle(2);
    // rst and flush together in ACC
    drive(0, 0, 1, 3'd1, 0, '0, 32'h5555_AAAA);
    drive(0, 0, 1, 3'd4, 1, 64'h0123_4567_89AB_CDEF, '0);
    drive(1, 1, 0, 3'd0, 0, '0, '0);
    idle(2);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), {$urandom, $urandom}, $urandom);
    end
    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
